// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR generator/checker pair.
package lfsr_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  localparam logic [7:0] LFSR8_ZERO = 8'h00;

  // Right-shifting Fibonacci LFSR; feedback taps bits 4,3,2,0 into bit 7.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
    return {q[4] ^ q[3] ^ q[2] ^ q[0], q[7:1]};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised saturating up-counter; a clear and an increment in the
// same cycle yield a count of one.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] base;

  always_comb begin
    base  = clr_i ? '0 : cnt_q;
    cnt_d = base;
    if (inc_i && (base != MAX_VAL)) begin
      cnt_d = base + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit LFSR stream: self-seeds, locks after a
// run of correct predictions, then flywheels and counts mismatches.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [7:0]       expected
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

  chk_state_t state_q;
  logic [3:0] match_q;
  logic [3:0] miss_q;
  logic [7:0] expected_q;
  logic       locked_q;
  logic       err_q;

  logic       hit;
  logic       nonzero;
  logic       err_inc;
  logic [3:0] match_inc;
  logic [3:0] miss_inc;

  assign hit       = (in_data == expected_q);
  assign nonzero   = (in_data != LFSR8_ZERO);
  assign err_inc   = in_valid && (state_q == LOCKED) && !hit;
  assign match_inc = match_q + 4'd1;
  assign miss_inc  = miss_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      match_q    <= 4'd0;
      miss_q     <= 4'd0;
      expected_q <= LFSR8_ZERO;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (in_valid) begin
        case (state_q)
          HUNT: begin
            if (nonzero) begin
              expected_q <= lfsr8_next(in_data);
              match_q    <= 4'd0;
              state_q    <= SYNC;
            end
          end
          SYNC: begin
            if (hit) begin
              expected_q <= lfsr8_next(in_data);
              match_q    <= match_inc;
              if (match_inc == LOCK_N) begin
                state_q  <= LOCKED;
                miss_q   <= 4'd0;
                locked_q <= 1'b1;
              end
            end else if (nonzero) begin
              expected_q <= lfsr8_next(in_data);
              match_q    <= 4'd0;
            end else begin
              state_q <= HUNT;
            end
          end
          LOCKED: begin
            // Flywheel: the received byte never reseeds once locked.
            expected_q <= lfsr8_next(expected_q);
            if (hit) begin
              miss_q <= 4'd0;
            end else begin
              err_q  <= 1'b1;
              miss_q <= miss_inc;
              if (miss_inc == LOSS_N) begin
                state_q  <= HUNT;
                locked_q <= 1'b0;
              end
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr_i(clr_cnt),
    .inc_i(err_inc),
    .cnt_o(err_cnt)
  );

  assign locked   = locked_q;
  assign err      = err_q;
  assign expected = expected_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker with hand-computed LFSR values, plus a
// narrow sat_counter instance to reach saturation quickly.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        clr_cnt;
  logic        locked;
  logic        err;
  logic [15:0] err_cnt;
  logic [7:0]  expected;

  logic        sc_rst;
  logic        sc_clr;
  logic        sc_inc;
  logic [1:0]  sc_cnt;

  int passes = 0;
  int total  = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  lfsr_checker #(
    .LOCK_CNT(4),
    .LOSS_CNT(3),
    .CNT_W   (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_data (in_data),
    .clr_cnt (clr_cnt),
    .locked  (locked),
    .err     (err),
    .err_cnt (err_cnt),
    .expected(expected)
  );

  sat_counter #(
    .WIDTH(2)
  ) sc (
    .clk  (clk),
    .rst  (sc_rst),
    .clr_i(sc_clr),
    .inc_i(sc_inc),
    .cnt_o(sc_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic c);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_data  = d;
    clr_cnt  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic sc_cyc(input logic r, input logic c, input logic i);
    @(negedge clk);
    sc_rst = r;
    sc_clr = c;
    sc_inc = i;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic l, input logic e,
                         input logic [15:0] n, input logic [7:0] x);
    chk({tag, ".locked"},   {31'd0, locked}, {31'd0, l});
    chk({tag, ".err"},      {31'd0, err},    {31'd0, e});
    chk({tag, ".err_cnt"},  {16'd0, err_cnt}, {16'd0, n});
    chk({tag, ".expected"}, {24'd0, expected}, {24'd0, x});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; clr_cnt = 1'b0;
    sc_rst = 1'b1; sc_clr = 1'b0; sc_inc = 1'b0;

    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk_all("reset", 1'b0, 1'b0, 16'd0, 8'h00);

    // Gapless lock: 01,80,40,20,10
    cyc(1'b0, 1'b1, 8'h01, 1'b0); chk_all("seed01", 1'b0, 1'b0, 16'd0, 8'h80);
    cyc(1'b0, 1'b1, 8'h80, 1'b0); chk_all("m1", 1'b0, 1'b0, 16'd0, 8'h40);
    cyc(1'b0, 1'b1, 8'h40, 1'b0); chk_all("m2", 1'b0, 1'b0, 16'd0, 8'h20);
    cyc(1'b0, 1'b1, 8'h20, 1'b0); chk_all("m3", 1'b0, 1'b0, 16'd0, 8'h10);
    cyc(1'b0, 1'b1, 8'h10, 1'b0); chk_all("lock", 1'b1, 1'b0, 16'd0, 8'h88);

    // Single corruption then recovery: 88 -> C4 (sent as 00) -> E2 -> 71
    cyc(1'b0, 1'b1, 8'h88, 1'b0); chk_all("lk88", 1'b1, 1'b0, 16'd0, 8'hC4);
    cyc(1'b0, 1'b1, 8'h00, 1'b0); chk_all("bad1", 1'b1, 1'b1, 16'd1, 8'hE2);
    cyc(1'b0, 1'b1, 8'hE2, 1'b0); chk_all("fly", 1'b1, 1'b0, 16'd1, 8'h71);

    // Three consecutive misses: 71 -> 38 -> 1C -> 8E, lock lost on the third
    cyc(1'b0, 1'b1, 8'h55, 1'b0); chk_all("loss1", 1'b1, 1'b1, 16'd2, 8'h38);
    cyc(1'b0, 1'b1, 8'h55, 1'b0); chk_all("loss2", 1'b1, 1'b1, 16'd3, 8'h1C);
    cyc(1'b0, 1'b1, 8'h55, 1'b0); chk_all("loss3", 1'b0, 1'b1, 16'd4, 8'h8E);
    cyc(1'b0, 1'b0, 8'h77, 1'b0); chk_all("idle", 1'b0, 1'b0, 16'd4, 8'h8E);

    // HUNT ignores zero seeds
    cyc(1'b0, 1'b1, 8'h00, 1'b0); chk_all("hz1", 1'b0, 1'b0, 16'd4, 8'h8E);
    cyc(1'b0, 1'b1, 8'h00, 1'b0); chk_all("hz2", 1'b0, 1'b0, 16'd4, 8'h8E);
    cyc(1'b0, 1'b1, 8'h01, 1'b0); chk_all("hseed", 1'b0, 1'b0, 16'd4, 8'h80);

    // Gapped stream 01,-,80,-,40,-,20,-,10 with junk data in the gaps
    cyc(1'b0, 1'b1, 8'h01, 1'b0); chk_all("g01", 1'b0, 1'b0, 16'd4, 8'h80);
    cyc(1'b0, 1'b0, 8'h00, 1'b0); chk_all("gap1", 1'b0, 1'b0, 16'd4, 8'h80);
    cyc(1'b0, 1'b1, 8'h80, 1'b0); chk_all("g80", 1'b0, 1'b0, 16'd4, 8'h40);
    cyc(1'b0, 1'b0, 8'h33, 1'b0); chk_all("gap2", 1'b0, 1'b0, 16'd4, 8'h40);
    cyc(1'b0, 1'b1, 8'h40, 1'b0); chk_all("g40", 1'b0, 1'b0, 16'd4, 8'h20);
    cyc(1'b0, 1'b0, 8'h00, 1'b0); chk_all("gap3", 1'b0, 1'b0, 16'd4, 8'h20);
    cyc(1'b0, 1'b1, 8'h20, 1'b0); chk_all("g20", 1'b0, 1'b0, 16'd4, 8'h10);
    cyc(1'b0, 1'b0, 8'h10, 1'b0); chk_all("gap4", 1'b0, 1'b0, 16'd4, 8'h10);
    cyc(1'b0, 1'b1, 8'h10, 1'b0); chk_all("glock", 1'b1, 1'b0, 16'd4, 8'h88);

    // Count to 5, then clear colliding with a mismatch
    cyc(1'b0, 1'b1, 8'h00, 1'b0); chk_all("bad5", 1'b1, 1'b1, 16'd5, 8'hC4);
    cyc(1'b0, 1'b1, 8'hC4, 1'b0); chk_all("okC4", 1'b1, 1'b0, 16'd5, 8'hE2);
    cyc(1'b0, 1'b1, 8'h00, 1'b1); chk_all("clrcol", 1'b1, 1'b1, 16'd1, 8'h71);
    cyc(1'b0, 1'b0, 8'h00, 1'b1); chk_all("clr", 1'b1, 1'b0, 16'd0, 8'h71);
    cyc(1'b0, 1'b1, 8'h00, 1'b0); chk_all("bad6", 1'b1, 1'b1, 16'd1, 8'h38);

    // Reset mid-lock wins over valid data and clear
    cyc(1'b1, 1'b1, 8'h38, 1'b1); chk_all("rstlk", 1'b0, 1'b0, 16'd0, 8'h00);
    cyc(1'b0, 1'b1, 8'h10, 1'b0); chk_all("rseed", 1'b0, 1'b0, 16'd0, 8'h88);

    // Saturation on a 2-bit counter
    sc_cyc(1'b1, 1'b0, 1'b0); chk("sc.rst", {30'd0, sc_cnt}, 32'd0);
    sc_cyc(1'b0, 1'b0, 1'b1); chk("sc.inc1", {30'd0, sc_cnt}, 32'd1);
    sc_cyc(1'b0, 1'b0, 1'b1); chk("sc.inc2", {30'd0, sc_cnt}, 32'd2);
    sc_cyc(1'b0, 1'b0, 1'b1); chk("sc.inc3", {30'd0, sc_cnt}, 32'd3);
    sc_cyc(1'b0, 1'b0, 1'b1); chk("sc.sat", {30'd0, sc_cnt}, 32'd3);
    sc_cyc(1'b0, 1'b0, 1'b0); chk("sc.hold", {30'd0, sc_cnt}, 32'd3);
    sc_cyc(1'b0, 1'b1, 1'b1); chk("sc.clrinc", {30'd0, sc_cnt}, 32'd1);
    sc_cyc(1'b0, 1'b1, 1'b0); chk("sc.clr", {30'd0, sc_cnt}, 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
